// File: rtl/load_store_unit_pkg.sv
// Shared core package: ALU/writeback selects, LSU op encodings, LSU FSM state type
// and the access-size helpers used by the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
    } alu_op_e;

    typedef enum logic [1:0] {
        WbAlu, WbLsu, WbPc4, WbImm
    } wb_sel_e;

    typedef enum logic [2:0] {
        StoreByte = 3'd0,
        StoreHalf = 3'd1,
        StoreWord = 3'd2
    } store_op_e;

    typedef enum logic [2:0] {
        LoadByte  = 3'd0,
        LoadByteU = 3'd1,
        LoadHalf  = 3'd2,
        LoadHalfU = 3'd3,
        LoadWord  = 3'd4
    } load_op_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } lsu_size_e;

    // FSM state kept as plain constants so legacy code can compare raw encodings
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_REQ  = 2'd1;
    localparam lsu_state_t LSU_RSP  = 2'd2;
    localparam lsu_state_t LSU_DONE = 2'd3;

    // Unknown op codes fall through to word size
    function automatic lsu_size_e lsu_size(input logic store_en, input logic [2:0] store_op,
                                           input logic [2:0] load_op);
        if (store_en) begin
            case (store_op)
                StoreByte: return SizeByte;
                StoreHalf: return SizeHalf;
                default:   return SizeWord;
            endcase
        end else begin
            case (load_op)
                LoadByte, LoadByteU: return SizeByte;
                LoadHalf, LoadHalfU: return SizeHalf;
                default:             return SizeWord;
            endcase
        end
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SizeHalf: return addr_lo[0];
            SizeWord: return |addr_lo;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering for stores (byte enables, replicated data) and
// lane extraction with sign/zero extension for loads.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic        store_en,
    input  logic [2:0]  store_op,
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    lsu_size_e   size;
    logic [31:0] rdata_shift;

    // Store steering: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        size       = lsu_size(store_en, store_op, load_op);
        wstrb      = 4'b0000;
        wdata_lane = wdata;
        case (size)
            SizeByte: begin
                wdata_lane = {4{wdata[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
            end
            SizeHalf: begin
                wdata_lane = {2{wdata[15:0]}};
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: wstrb = 4'b1111;
        endcase
        if (!store_en) wstrb = 4'b0000;
    end

    // Load extraction: shift the addressed lane down, then extend
    always_comb begin
        rdata_shift = rdata >> {addr_lo, 3'b000};
        case (load_op)
            LoadByte:  rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            LoadByteU: rdata_ext = {24'h0, rdata_shift[7:0]};
            LoadHalf:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            LoadHalfU: rdata_ext = {16'h0, rdata_shift[15:0]};
            default:   rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one command in IDLE, rejects misaligned accesses,
// runs a request/response handshake with data memory and pulses done once.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_eu_lsu_valid,
    input  logic              i_eu_lsu_store_en,
    input  logic [2:0]        i_eu_lsu_store_op,
    input  logic [2:0]        i_eu_lsu_load_op,
    input  logic [ADDR_W-1:0] i_eu_lsu_addr,
    input  logic [31:0]       i_eu_lsu_wdata,
    output logic              o_eu_lsu_busy,
    output logic              o_eu_lsu_done,
    output logic              o_eu_lsu_misaligned,
    output logic [31:0]       o_eu_lsu_rdata,
    output logic              o_dm_req_valid,
    input  logic              i_dm_req_ready,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic              o_dm_we,
    output logic [3:0]        o_dm_wstrb,
    output logic [31:0]       o_dm_wdata,
    input  logic              i_dm_rsp_valid,
    output logic              o_dm_rsp_ready,
    input  logic [31:0]       i_dm_rsp_rdata
);

    lsu_state_t        state_q, state_d;
    logic              store_en_q;
    logic [2:0]        store_op_q, load_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic              mis_q;
    logic              cmd_mis;
    logic [31:0]       rdata_ext;

    assign cmd_mis = lsu_misaligned(lsu_size(i_eu_lsu_store_en, i_eu_lsu_store_op,
                                             i_eu_lsu_load_op),
                                    i_eu_lsu_addr[1:0]);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (i_eu_lsu_valid) state_d = cmd_mis ? LSU_DONE : LSU_REQ;
            LSU_REQ:  if (i_dm_req_ready) state_d = store_en_q ? LSU_DONE : LSU_RSP;
            LSU_RSP:  if (i_dm_rsp_valid) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State, command capture and load result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= LSU_IDLE;
            store_en_q <= 1'b0;
            store_op_q <= 3'd0;
            load_op_q  <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            mis_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == LSU_IDLE && i_eu_lsu_valid) begin
                mis_q <= cmd_mis;
                // Misaligned commands never reach the bus, so leave its fields untouched
                if (!cmd_mis) begin
                    store_en_q <= i_eu_lsu_store_en;
                    store_op_q <= i_eu_lsu_store_op;
                    load_op_q  <= i_eu_lsu_load_op;
                    addr_q     <= i_eu_lsu_addr;
                    wdata_q    <= i_eu_lsu_wdata;
                end
            end
            if (state_q == LSU_RSP && i_dm_rsp_valid) rdata_q <= rdata_ext;
        end
    end

    lsu_lane_align u_lane_align (
        .store_en   (store_en_q),
        .store_op   (store_op_q),
        .load_op    (load_op_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (i_dm_rsp_rdata),
        .wstrb      (o_dm_wstrb),
        .wdata_lane (o_dm_wdata),
        .rdata_ext  (rdata_ext)
    );

    // Status and handshake outputs decoded from the registered state
    always_comb begin
        o_eu_lsu_busy       = (state_q != LSU_IDLE);
        o_eu_lsu_done       = (state_q == LSU_DONE);
        o_eu_lsu_misaligned = (state_q == LSU_DONE) && mis_q;
        o_eu_lsu_rdata      = rdata_q;
        o_dm_req_valid      = (state_q == LSU_REQ);
        o_dm_rsp_ready      = (state_q == LSU_RSP);
        o_dm_addr           = {addr_q[ADDR_W-1:2], 2'b00};
        o_dm_we             = store_en_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid, store_en;
    logic [2:0]    store_op, load_op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy, done, misaligned;
    logic [31:0]   rdata;
    logic          req_valid, req_ready;
    logic [AW-1:0] dm_addr;
    logic          dm_we;
    logic [3:0]    dm_wstrb;
    logic [31:0]   dm_wdata;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_eu_lsu_valid      (valid),
        .i_eu_lsu_store_en   (store_en),
        .i_eu_lsu_store_op   (store_op),
        .i_eu_lsu_load_op    (load_op),
        .i_eu_lsu_addr       (addr),
        .i_eu_lsu_wdata      (wdata),
        .o_eu_lsu_busy       (busy),
        .o_eu_lsu_done       (done),
        .o_eu_lsu_misaligned (misaligned),
        .o_eu_lsu_rdata      (rdata),
        .o_dm_req_valid      (req_valid),
        .i_dm_req_ready      (req_ready),
        .o_dm_addr           (dm_addr),
        .o_dm_we             (dm_we),
        .o_dm_wstrb          (dm_wstrb),
        .o_dm_wdata          (dm_wdata),
        .i_dm_rsp_valid      (rsp_valid),
        .o_dm_rsp_ready      (rsp_ready),
        .i_dm_rsp_rdata      (rsp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes, straight from the op tables (unknown -> word)
    function automatic int unsigned ref_size(input logic st, input logic [2:0] op);
        if (st) return (op == StoreByte) ? 1 : (op == StoreHalf) ? 2 : 4;
        return (op == LoadByte || op == LoadByteU) ? 1 :
               (op == LoadHalf || op == LoadHalfU) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic st, input int unsigned sz,
                                             input logic [31:0] a);
        int unsigned m;
        if (!st) return 4'b0000;
        m = ((32'd1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int unsigned sz, input logic [31:0] w);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] word);
        int unsigned sz;
        logic [31:0] v, mask;
        sz   = ref_size(1'b0, op);
        v    = word >> (8 * (a % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        v    = v & mask;
        if ((op == LoadByte || op == LoadHalf) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One full transaction with the given wait states; spurious traffic optional
    task automatic run_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int req_wait, input int rsp_wait,
                          input logic [31:0] word, input logic inject);
        int unsigned sz;
        logic        mis;
        logic [31:0] exp_addr;
        sz       = ref_size(st, op);
        mis      = (a % sz) != 0;
        exp_addr = a & 32'hFFFF_FFFC;

        valid    = 1'b1;
        store_en = st;
        store_op = st ? op : 3'($urandom);
        load_op  = st ? 3'($urandom) : op;
        addr     = a;
        wdata    = wd;
        tick();
        valid = 1'b0;

        if (mis) begin
            check("mis_done", 32'(done), 32'd1);
            check("mis_flag", 32'(misaligned), 32'd1);
            check("mis_no_req", 32'(req_valid), 32'd0);
            tick();
            check("mis_done_clr", 32'(done), 32'd0);
            check("mis_busy_clr", 32'(busy), 32'd0);
            return;
        end

        check("req_valid", 32'(req_valid), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("req_addr", dm_addr, exp_addr);
        check("req_we", 32'(dm_we), 32'(st));
        check("req_wstrb", 32'(dm_wstrb), 32'(ref_wstrb(st, sz, a)));
        if (st) check("req_wdata", dm_wdata, ref_wdata(sz, wd));

        for (int i = 0; i < req_wait; i++) begin
            if (inject) begin
                valid     = 1'b1;
                store_en  = 1'($urandom);
                addr      = $urandom;
                rsp_valid = 1'b1;
                rsp_rdata = $urandom;
            end
            tick();
            check("hold_req_valid", 32'(req_valid), 32'd1);
            check("hold_addr", dm_addr, exp_addr);
            check("hold_we", 32'(dm_we), 32'(st));
            check("hold_rsp_ready", 32'(rsp_ready), 32'd0);
            check("hold_done", 32'(done), 32'd0);
        end
        valid     = 1'b0;
        rsp_valid = 1'b0;

        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;

        if (st) begin
            check("st_done", 32'(done), 32'd1);
            check("st_mis", 32'(misaligned), 32'd0);
            check("st_req_drop", 32'(req_valid), 32'd0);
        end else begin
            check("ld_rsp_ready", 32'(rsp_ready), 32'd1);
            check("ld_req_drop", 32'(req_valid), 32'd0);
            check("ld_early_done", 32'(done), 32'd0);
            for (int i = 0; i < rsp_wait; i++) begin
                tick();
                check("ld_wait_done", 32'(done), 32'd0);
                check("ld_wait_ready", 32'(rsp_ready), 32'd1);
            end
            rsp_valid = 1'b1;
            rsp_rdata = word;
            tick();
            rsp_valid = 1'b0;
            rsp_rdata = $urandom;
            check("ld_done", 32'(done), 32'd1);
            check("ld_mis", 32'(misaligned), 32'd0);
            check("ld_rdata", rdata, ref_load(op, a, word));
        end
        tick();
        check("end_done", 32'(done), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);
        check("rst_wstrb", 32'(dm_wstrb), 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_wdata", dm_wdata, 32'd0);
        check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        valid     = 1'b0;
        store_en  = 1'b0;
        store_op  = 3'd0;
        load_op   = 3'd0;
        addr      = '0;
        wdata     = 32'h0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs();

        // Directed corner cases
        run_op(1'b1, StoreByte, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
        run_op(1'b0, LoadHalf, 32'h0000_0202, 32'h0, 0, 3, 32'h8001_0000, 1'b0);
        run_op(1'b0, LoadByteU, 32'h0000_0201, 32'h0, 0, 0, 32'h0000_F000, 1'b0);
        run_op(1'b1, StoreWord, 32'h0000_0102, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
        run_op(1'b0, LoadWord, 32'h0000_0400, 32'h0, 5, 1, 32'hDEAD_BEEF, 1'b1);
        run_op(1'b1, 3'd7, 32'h0000_0200, 32'hCAFE_F00D, 1, 0, 32'h0, 1'b0);

        // Reset while waiting for a load response abandons the transfer
        valid    = 1'b1;
        store_en = 1'b0;
        load_op  = LoadWord;
        addr     = 32'h0000_0300;
        tick();
        valid     = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("pre_rst_rsp_ready", 32'(rsp_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs();
        rsp_valid = 1'b1;
        rsp_rdata = 32'h5555_AAAA;
        tick();
        rsp_valid = 1'b0;
        check("late_rsp_done", 32'(done), 32'd0);
        check("late_rsp_busy", 32'(busy), 32'd0);
        check("late_rsp_rdata", rdata, 32'd0);
        tick();
        check("late_rsp_done2", 32'(done), 32'd0);
        run_op(1'b0, LoadHalfU, 32'h0000_0302, 32'h0, 0, 0, 32'h9ABC_1234, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 80; n++) begin
            logic        st;
            logic [2:0]  op;
            logic [31:0] a;
            st = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            a  = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            run_op(st, op, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
